// File: rtl/reg_writeback_pkg.sv
// Shared constants and the buffered long-latency result entry for the writeback stage.
package reg_writeback_pkg;
  localparam int REG_ADDR_W     = 5;
  localparam int NUM_REGS       = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding {rd,data} MDU results until the write port is free.
// Registered count; read data is the combinational head entry.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;

  // Storage needs no reset: entries are only read while cnt says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter with MDU reservation scoreboard; ALU wins unless the MDU buffer is full.
// c_* are registered one edge after the selected result; pops clear busy at the same edge.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rs,
  input  logic [4:0]            issue_rt,
  input  logic [4:0]            issue_rd,
  input  logic                  issue_long,
  output logic                  issue_ready,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mdu_valid,
  input  logic [4:0]            mdu_rd,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  output logic [4:0]            c_addr,
  output logic                  c_we,
  output logic [DATA_W-1:0]     c_in,
  output logic [31:0]           busy
);
  localparam int ENTRY_W = REG_ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  mdu_push;
  logic                  take_fifo;
  logic                  take_alu;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0]     sel_data;
  logic                  issue_fire;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_nxt;

  assign mdu_ready = (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign alu_ready = (fifo_cnt != CNT_W'(FIFO_DEPTH));
  assign mdu_push  = mdu_valid & mdu_ready;

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mdu_push),
    .push_dat ({mdu_rd, mdu_data}),
    .pop      (take_fifo),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  // A full buffer must drain first so the MDU can never be starved by a stream of ALU results.
  assign take_fifo = fifo_full | (!alu_valid & !fifo_empty);
  assign take_alu  = !fifo_full & alu_valid;
  assign sel_rd    = take_fifo ? fifo_head[ENTRY_W-1 -: REG_ADDR_W] : alu_rd;
  assign sel_data  = take_fifo ? fifo_head[DATA_W-1:0] : alu_data;

  assign issue_ready = ~(busy_q[issue_rs] | busy_q[issue_rt] | busy_q[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready & issue_long & (issue_rd != '0);

  always_comb begin
    busy_nxt = busy_q;
    if (take_fifo) busy_nxt[sel_rd] = 1'b0;
    if (issue_fire) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      c_we   <= 1'b0;
      c_addr <= '0;
      c_in   <= '0;
    end else begin
      busy_q <= busy_nxt;
      if ((take_fifo | take_alu) && sel_rd != '0) begin
        c_we   <= 1'b1;
        c_addr <= sel_rd;
        c_in   <= sel_data;
      end else begin
        c_we   <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed table of per-cycle vectors for reg_writeback plus a hand-written reset-mid-flight sequence.
module tb_reg_writeback;
  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_long;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  c_addr;
  logic        c_we;
  logic [31:0] c_in;
  logic [31:0] busy;

  int n_vec  = 0;
  int n_miss = 0;

  reg_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_long(issue_long), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .c_addr(c_addr), .c_we(c_we), .c_in(c_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs, rt, rd;
    logic        il;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_ir, e_ar, e_mr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_cin;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0; issue_long = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          iv rs rt rd il  av ard adat          mv mrd mdat           ir ar mr  we addr cin           busy
    tbl.push_back('{1, 1, 2, 5, 1,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  0, 0,  32'h0,        32'h20});
    tbl.push_back('{1, 5, 0, 6, 0,  0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 1,  0, 0,  32'h0,        32'h20});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 1, 1, 1,  0, 0,  32'h0,        32'h20});
    tbl.push_back('{0, 5, 0, 0, 0,  0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 1,  1, 5,  32'hDEADBEEF, 32'h0});
    tbl.push_back('{0, 5, 0, 0, 0,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  0, 5,  32'hDEADBEEF, 32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 3, 32'h11,       1, 7,  32'h22,       1, 1, 1,  1, 3,  32'h11,       32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  1, 7,  32'h22,       32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  0, 7,  32'h22,       32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 9, 32'h99,       1, 10, 32'hA0A0,     1, 1, 1,  1, 9,  32'h99,       32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 9, 32'h99,       1, 11, 32'hB0B0,     1, 1, 1,  1, 9,  32'h99,       32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 9, 32'h99,       0, 0,  32'h0,        1, 0, 0,  1, 10, 32'hA0A0,     32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 9, 32'h99,       0, 0,  32'h0,        1, 1, 1,  1, 9,  32'h99,       32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 32'h0,        1, 12, 32'hC0C0,     1, 1, 1,  1, 11, 32'hB0B0,     32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  1, 12, 32'hC0C0,     32'h0});
    tbl.push_back('{1, 0, 0, 0, 1,  1, 0, 32'hFFFF,     0, 0,  32'h0,        1, 1, 1,  0, 12, 32'hC0C0,     32'h0});
    tbl.push_back('{0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  0, 12, 32'hC0C0,     32'h0});
    tbl.push_back('{1, 0, 0, 2, 1,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  0, 12, 32'hC0C0,     32'h04});
    tbl.push_back('{1, 0, 2, 3, 1,  0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 1,  0, 12, 32'hC0C0,     32'h04});
    tbl.push_back('{1, 1, 4, 3, 1,  0, 0, 32'h0,        0, 0,  32'h0,        1, 1, 1,  0, 12, 32'hC0C0,     32'h0C});
    tbl.push_back('{1, 0, 0, 2, 1,  0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 1,  0, 12, 32'hC0C0,     32'h0C});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 1, 32'h55,       1, 2,  32'h222,      1, 1, 1,  1, 1,  32'h55,       32'h0C});
    tbl.push_back('{0, 0, 0, 0, 0,  1, 1, 32'h55,       1, 3,  32'h333,      1, 1, 1,  1, 1,  32'h55,       32'h0C});

    rst_n = 1'b0;
    drive_idle();
    #12;
    chk("reset c_we", 32'(c_we), 32'h0);
    chk("reset c_addr", 32'(c_addr), 32'h0);
    chk("reset c_in", c_in, 32'h0);
    chk("reset busy", busy, 32'h0);
    chk("reset issue_ready", 32'(issue_ready), 32'h1);
    chk("reset alu_ready", 32'(alu_ready), 32'h1);
    chk("reset mdu_ready", 32'(mdu_ready), 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      issue_valid = tbl[i].iv; issue_rs = tbl[i].rs; issue_rt = tbl[i].rt;
      issue_rd = tbl[i].rd; issue_long = tbl[i].il;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
      mdu_valid = tbl[i].mv; mdu_rd = tbl[i].mrd; mdu_data = tbl[i].mdat;
      #1;
      chk($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("row%0d mdu_ready", i), 32'(mdu_ready), 32'(tbl[i].e_mr));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d c_we", i), 32'(c_we), 32'(tbl[i].e_we));
      chk($sformatf("row%0d c_addr", i), 32'(c_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d c_in", i), c_in, tbl[i].e_cin);
      chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
    end

    // Two MDU entries buffered behind a held ALU result, busy=0x0C; reset lands mid-cycle.
    mdu_valid = 0;
    #1;
    chk("full mdu_ready", 32'(mdu_ready), 32'h0);
    chk("full alu_ready", 32'(alu_ready), 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst c_we", 32'(c_we), 32'h0);
    chk("midrst c_addr", 32'(c_addr), 32'h0);
    chk("midrst c_in", c_in, 32'h0);
    chk("midrst busy", busy, 32'h0);
    chk("midrst mdu_ready", 32'(mdu_ready), 32'h1);
    chk("midrst alu_ready", 32'(alu_ready), 32'h1);
    drive_idle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst%0d c_we", k), 32'(c_we), 32'h0);
      chk($sformatf("postrst%0d busy", k), busy, 32'h0);
    end
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    @(posedge clk);
    #1;
    chk("postrst alu c_we", 32'(c_we), 32'h1);
    chk("postrst alu c_addr", 32'(c_addr), 32'h4);
    chk("postrst alu c_in", c_in, 32'h44);
    drive_idle();
    @(posedge clk);
    #1;
    chk("postrst idle c_we", 32'(c_we), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, long-latency result buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports issue_valid in 1, issue_rs in 5, issue_rt in 5, issue_rd in 5, issue_long in 1: decode-stage instruction offer; issue_long marks an MDU destination.
REQ-006 SHALL have port issue_ready  out  1  instruction may issue this cycle.
REQ-007 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in DATA_W: single-cycle result; alu_ready out 1.
REQ-008 SHALL have ports mdu_valid in 1, mdu_rd in 5, mdu_data in DATA_W: multi-cycle result; mdu_ready out 1.
REQ-009 SHALL have ports c_addr out 5, c_we out 1, c_in out DATA_W: registered drive of the register-file write port.
REQ-010 SHALL have port busy  out  32  scoreboard, bit n = register n awaits an MDU result.

Function
REQ-011 issue_ready SHALL be !busy[issue_rs] & !busy[issue_rt] & !busy[issue_rd], from registered busy only (no same-cycle clear bypass).
REQ-012 Issue handshake: issue_valid & issue_ready & issue_long & issue_rd!=0 SHALL set busy[issue_rd] at the edge; non-long issues SHALL not touch busy.
REQ-013 busy[0] SHALL be constant 0.
REQ-014 mdu_ready SHALL be (FIFO count < FIFO_DEPTH) from registered count; mdu_valid & mdu_ready SHALL push {mdu_rd, mdu_data}.
REQ-015 alu_ready SHALL be (FIFO count != FIFO_DEPTH); alu_valid while alu_ready=0 SHALL be ignored (upstream holds).
REQ-016 Write-port arbitration per edge: FIFO full -> pop FIFO; else alu_valid -> take ALU; else FIFO non-empty -> pop FIFO; else idle.
REQ-017 Selected item with rd!=0: next c_we=1, c_addr=rd, c_in=data; rd==0 or idle: next c_we=0, c_addr/c_in hold.
REQ-018 Pop SHALL clear busy[popped rd] at the same edge; write then appears on c_* the following cycle, covered by the register file's write-forwarding.
REQ-019 Push and pop in the same edge SHALL both occur; count unchanged; push into a full FIFO SHALL never happen (REQ-014).
REQ-020 FIFO order SHALL be strict FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-021 Latency: ALU result to c_we = 1 cycle; MDU result to c_we >= 1 cycle.
REQ-022 Set and clear of the same busy bit in one edge cannot occur (set needs bit clear); no priority rule needed.

Reset
REQ-023 rst_n low SHALL immediately force c_we=0, c_addr=0, c_in=0, busy=0, FIFO empty (count=0, pointers 0).
REQ-024 Reset mid-operation SHALL discard buffered MDU results and reservations without any write; first write possible one edge after rst_n rises.

Structure
REQ-025 Shared package SHALL hold REG_ADDR_W=5, NUM_REGS=32, DATA_W default, FIFO_DEPTH default, and the {rd,data} result-entry typedef.
REQ-026 FIFO SHALL be sub-module wb_fifo (push/pop/full/empty/count, async active-low reset); scoreboard and arbitration stay in reg_writeback.

Verification
REQ-027 Reserve-and-stall: issue long rd=5; next cycle offer rs=5 -> issue_ready=0, busy=0x20; mdu push rd=5 0xDEADBEEF -> next edge busy=0, following cycle c_we=1 c_addr=5 c_in=0xDEADBEEF, issue_ready=1.
REQ-028 ALU priority: alu rd=3 0x11 and mdu rd=7 0x22 same cycle, FIFO empty -> cycle+1 writes r3=0x11, cycle+2 writes r7=0x22.
REQ-029 FIFO full: hold alu_valid every cycle, push 2 MDU results -> mdu_ready=0, alu_ready=0, next write is oldest MDU entry, then ALU resumes.
REQ-030 r0 discard: alu rd=0 0xFFFF and long issue rd=0 -> c_we stays 0, busy stays 0.
REQ-031 Reset mid-flight: 2 entries buffered, busy=0x0C, pull rst_n low -> c_we=0, busy=0, mdu_ready=1 immediately; no write after release.
